jam: RTL and testbench
======================

// Module: jam
// PURPOSE
//  Job Assignment Machine: exhaustive search over all 8! = 40320 assignments of 8 workers to 8 jobs.
//  Fetches 7-bit costs from an external cost ROM addressed by (W,J), with one-cycle read latency.
//  Reports the minimum total cost and how many assignments achieve it, then raises Valid.
//  Sits beside a synchronous cost ROM; standalone accelerator, no host handshake beyond reset.
// PARAMETERS
//  N_W   8  workers/jobs (fixed; permutation logic sized for 8, not re-parameterisable)
// PORTS
//  CLK         in   1  single clock, rising edge
//  RST         in   1  reset, asynchronous, active-high
//  W           out  3  worker index of cost lookup
//  J           out  3  job index of cost lookup
//  Cost        in   7  cost[W][J] of address driven in the PREVIOUS cycle (ROM registers W/J on CLK)
//  MatchCount  out  4  number of assignments reaching MinCost (saturating)
//  MinCost     out  9  minimum total cost (saturating)
//  Valid       out  1  results valid
// BEHAVIOUR
//  Reset: W=0, J=0, MinCost=0, MatchCount=0, Valid=0, perm=identity, best=10'h3FF, cnt=0, state IDLE.
//  Permutation p[0..7] = job of worker i; starts at identity 0,1,..,7; stepped in lexicographic order
//   (pivot = rightmost i with p[i]<p[i+1]; swap with smallest larger suffix entry; reverse suffix).
//   Last permutation 7,6,..,0 (no pivot) ends search; every permutation evaluated exactly once.
//  FSM: IDLE -> FETCH -> CMP -> (NEXT -> FETCH | DONE).
//   FETCH: 8 cycles drive W=i, J=p[i], i=0..7; Cost accumulated one cycle later into 10-bit sum.
//   CMP: sum<best -> best=sum, cnt=1; sum==best -> cnt=cnt+1 (saturates at 15); else no change.
//   NEXT: compute next permutation in one cycle. Target <=10 cycles per permutation.
//  DONE: MinCost = (best>511) ? 511 : best[8:0]; MatchCount = cnt; Valid=1 from next edge.
//   Outputs and Valid held stable in DONE until RST; W/J frozen.
//  MinCost/MatchCount read 0 until DONE (no running values exposed).
//  Sum width 10 bits (max 8*127=1016), comparisons at full width; no wrap.
//  RST mid-search: immediate abort, all state to reset values, search restarts from identity after release.
//  Valid asserted no later than 500000 cycles after RST deassertion.
// CONFIGURATION
//  JAM_COST_CACHE_EN defined: LOAD state after IDLE issues 64 reads (W=a[5:3], J=a[2:0], a=0..63),
//   stores Cost one cycle later in a 64x7 register file; then evaluates one permutation per cycle
//   (8-way adder over cache + compare + next-perm in same cycle); W/J idle at 0 after LOAD.
//   Valid within 41000 cycles of reset release.
//  Undefined: ROM-fetch flow as above (8 reads per permutation); no cost storage.
//  Final MinCost/MatchCount identical in both builds; only Valid timing differs.
// TESTING
//  Cost=1 on diagonal, 50 elsewhere -> MinCost=8, MatchCount=1 (first permutation wins).
//  Cost=0 on anti-diagonal (J=7-W), 100 elsewhere -> MinCost=0, MatchCount=1 (last permutation).
//  Cost[w][j]=w+j -> every sum 56 -> MinCost=56, MatchCount=15 (saturated).
//  All costs 127 -> MinCost=511 (saturated from 1016), MatchCount=15.
//  Diagonal 1, cost[0][1]=cost[1][0]=1, rest 60 -> MinCost=8, MatchCount=2.
//  Assert RST mid-search, release -> same results as clean run; Valid low while RST, stays 1 after DONE.

Source files
------------

// File: rtl/jam.sv
// -----------------------------------------------------------------------------
// jam -- Job Assignment Machine
//
// Purpose:
//   Exhaustive search over all 8! assignments of 8 workers to 8 jobs. Costs
//   come from an external synchronous cost ROM (one-cycle read latency). The
//   permutation p[i] (job of worker i) starts at the identity and is stepped
//   in lexicographic order until 7,6,..,0. The minimum total cost and the
//   number of assignments reaching it are reported, then Valid is raised.
//
// Ports:
//   CLK         in   1  clock, rising edge
//   RST         in   1  asynchronous active-high reset
//   W           out  3  worker index of cost lookup
//   J           out  3  job index of cost lookup
//   Cost        in   7  cost[W][J] of the address driven in the previous cycle
//   MatchCount  out  4  assignments reaching MinCost (saturates at 15)
//   MinCost     out  9  minimum total cost (saturates at 511)
//   Valid       out  1  results valid, held until RST
//
// Configuration macro: JAM_COST_CACHE_EN
//   Defined   : the 64 costs are read once into a local register file, then
//               one permutation is evaluated per clock.
//   Undefined : eight ROM reads per permutation (FETCH/CMP/NEXT, 10 cycles).
// -----------------------------------------------------------------------------
module jam (
   input  logic       CLK,
   input  logic       RST,
   output logic [2:0] W,
   output logic [2:0] J,
   input  logic [6:0] Cost,
   output logic [3:0] MatchCount,
   output logic [8:0] MinCost,
   output logic       Valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CMP, S_NEXT, S_LOAD, S_EVAL, S_DONE
   } state_t;

   state_t      state_reg, state_next;

   logic [2:0]  perm_reg [8];
   logic [2:0]  perm_step [8];
   logic [2:0]  swp [8];
   logic        has_pivot;
   logic [2:0]  piv;
   logic [2:0]  succ;

   logic [9:0]  best_reg;
   logic [3:0]  cnt_reg;
   logic [9:0]  total;
   logic        cmp_en;

   logic [8:0]  min_out_reg;
   logic [3:0]  cnt_out_reg;
   logic        valid_reg;

`ifdef JAM_COST_CACHE_EN
   logic [6:0]  ld_cnt_reg;      // 0..64: issue address ld_cnt, store ld_cnt-1
   logic [6:0]  cache [64];
   logic [9:0]  cache_sum;
`else
   logic [2:0]  idx_reg;
   logic [9:0]  sum_reg;
`endif

   // ---------------------------------------------------------------------
   // Next lexicographic permutation. The suffix after the pivot is strictly
   // decreasing, so the rightmost entry larger than p[piv] is also the
   // smallest larger one.
   // ---------------------------------------------------------------------
   always_comb begin
      has_pivot = 1'b0;
      piv       = 3'd0;
      succ      = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (perm_reg[i] < perm_reg[i+1]) begin
            has_pivot = 1'b1;
            piv       = 3'(i);
         end
      end
      for (int j = 0; j < 8; j++) begin
         if ((3'(j) > piv) && (perm_reg[j] > perm_reg[piv]))
            succ = 3'(j);
      end
      for (int k = 0; k < 8; k++)
         swp[k] = perm_reg[k];
      swp[piv]  = perm_reg[succ];
      swp[succ] = perm_reg[piv];
   end

   // Suffix reversal: position k > piv takes element piv+8-k, which is
   // exactly the 3-bit wrap of piv-k.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_step
         localparam logic [2:0] K = 3'(gi);
         logic [2:0] src;
         assign src           = piv - K;
         assign perm_step[gi] = (K > piv) ? swp[src] : swp[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
`ifdef JAM_COST_CACHE_EN
         S_IDLE:  state_next = S_LOAD;
         S_LOAD:  if (ld_cnt_reg == 7'd64) state_next = S_EVAL;
         S_EVAL:  if (!has_pivot) state_next = S_DONE;
`else
         S_IDLE:  state_next = S_FETCH;
         S_FETCH: if (idx_reg == 3'd7) state_next = S_CMP;
         S_CMP:   state_next = has_pivot ? S_NEXT : S_DONE;
         S_NEXT:  state_next = S_FETCH;
`endif
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (ROM address, compare strobe, permutation total)
   // ---------------------------------------------------------------------
`ifdef JAM_COST_CACHE_EN
   always_comb begin
      cache_sum = 10'd0;
      for (int i = 0; i < 8; i++)
         cache_sum = cache_sum + {3'b000, cache[{3'(i), perm_reg[i]}]};
   end
`endif

   always_comb begin
      W      = 3'd0;
      J      = 3'd0;
      cmp_en = 1'b0;
`ifdef JAM_COST_CACHE_EN
      total  = cache_sum;
      case (state_reg)
         S_LOAD: begin
            if (ld_cnt_reg < 7'd64) begin
               W = ld_cnt_reg[5:3];
               J = ld_cnt_reg[2:0];
            end
         end
         S_EVAL:  cmp_en = 1'b1;
         default: ;
      endcase
`else
      // The eighth cost lands during CMP, so it is folded in here.
      total  = sum_reg + {3'b000, Cost};
      case (state_reg)
         S_FETCH: begin
            W = idx_reg;
            J = perm_reg[idx_reg];
         end
         S_CMP:   cmp_en = 1'b1;
         default: ;
      endcase
`endif
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 8; i++)
            perm_reg[i] <= 3'(i);
         best_reg    <= 10'h3FF;
         cnt_reg     <= 4'd0;
         min_out_reg <= 9'd0;
         cnt_out_reg <= 4'd0;
         valid_reg   <= 1'b0;
`ifdef JAM_COST_CACHE_EN
         ld_cnt_reg  <= 7'd0;
`else
         idx_reg     <= 3'd0;
         sum_reg     <= 10'd0;
`endif
      end else begin
         if (cmp_en) begin
            if (total < best_reg) begin
               best_reg <= total;
               cnt_reg  <= 4'd1;
            end else if ((total == best_reg) && (cnt_reg != 4'd15)) begin
               cnt_reg  <= cnt_reg + 4'd1;
            end
         end
`ifdef JAM_COST_CACHE_EN
         if (state_reg == S_LOAD)
            ld_cnt_reg <= ld_cnt_reg + 7'd1;
         if ((state_reg == S_EVAL) && has_pivot)
            for (int i = 0; i < 8; i++)
               perm_reg[i] <= perm_step[i];
`else
         if (state_reg == S_FETCH) begin
            idx_reg <= idx_reg + 3'd1;
            // Cost seen at idx 0 belongs to the previous permutation.
            sum_reg <= (idx_reg == 3'd0) ? 10'd0 : sum_reg + {3'b000, Cost};
         end
         if (state_reg == S_NEXT)
            for (int i = 0; i < 8; i++)
               perm_reg[i] <= perm_step[i];
`endif
         if (state_reg == S_DONE) begin
            min_out_reg <= (best_reg > 10'd511) ? 9'd511 : best_reg[8:0];
            cnt_out_reg <= cnt_reg;
            valid_reg   <= 1'b1;
         end
      end
   end

`ifdef JAM_COST_CACHE_EN
   // Cost arrives one cycle after its address, hence the -1 slot.
   always_ff @(posedge CLK) begin
      if ((state_reg == S_LOAD) && (ld_cnt_reg != 7'd0))
         cache[6'(ld_cnt_reg - 7'd1)] <= Cost;
   end
`endif

   assign MinCost    = min_out_reg;
   assign MatchCount = cnt_out_reg;
   assign Valid      = valid_reg;

endmodule

// File: tb/tb_jam.sv
// -----------------------------------------------------------------------------
// tb_jam -- scoreboard bench for jam. A cost ROM model with one-cycle latency
// sits beside the DUT. Expected results come from a subset dynamic program
// over assigned jobs; a monitor pops them when Valid first rises.
// -----------------------------------------------------------------------------
module tb_jam;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic [3:0] MatchCount;
   logic [8:0] MinCost;
   logic       Valid;

   logic [6:0] rom [64];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int min_cost;
      int match;
   } exp_t;

   exp_t exp_q[$];
   bit   seen = 1'b0;

   jam dut (
      .CLK        (CLK),
      .RST        (RST),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .MatchCount (MatchCount),
      .MinCost    (MinCost),
      .Valid      (Valid)
   );

   always #5 CLK = ~CLK;

   // Synchronous cost ROM
   always @(posedge CLK) Cost <= rom[{W, J}];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // dmin[m]/dcnt[m]: best cost and its multiplicity when workers
   // 0..popcount(m)-1 take exactly the job set m.
   function automatic void model(output int mn, output int ct);
      int dmin [256];
      int dcnt [256];
      int w, p, c;
      dmin[0] = 0;
      dcnt[0] = 1;
      for (int m = 1; m < 256; m++) begin
         w       = $countones(m) - 1;
         dmin[m] = 1 << 30;
         dcnt[m] = 0;
         for (int j = 0; j < 8; j++) begin
            if (((m >> j) & 1) == 1) begin
               p = m & ~(1 << j);
               c = dmin[p] + int'(rom[w*8 + j]);
               if (c < dmin[m]) begin
                  dmin[m] = c;
                  dcnt[m] = dcnt[p];
               end else if (c == dmin[m]) begin
                  dcnt[m] = dcnt[m] + dcnt[p];
               end
            end
         end
      end
      mn = (dmin[255] > 511) ? 511 : dmin[255];
      ct = (dcnt[255] > 15) ? 15 : dcnt[255];
   endfunction

   // Monitor: compares the first result presented after each reset release
   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            seen = 1'b0;
         end else if (Valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("min_cost", int'(MinCost), e.min_cost);
               check("match_count", int'(MatchCount), e.match);
            end
         end
      end
   end

   task automatic run_search(input string name);
      int   mn, ct, cyc;
      exp_t e;
      model(mn, ct);
      e.min_cost = mn;
      e.match    = ct;
      exp_q.push_back(e);
      @(negedge CLK);
      RST = 1'b0;
      cyc = 0;
      while (!Valid && cyc < 500000) begin
         @(negedge CLK);
         cyc++;
      end
      if (!Valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=%0d required<500000", name, cyc);
         exp_q.delete();
      end else begin
         repeat (16) @(negedge CLK);
         check({name, "_hold_min"},   int'(MinCost),    mn);
         check({name, "_hold_cnt"},   int'(MatchCount), ct);
         check({name, "_hold_valid"}, int'(Valid),      1);
         $display("run %s min=%0d cnt=%0d exp_min=%0d exp_cnt=%0d cycles=%0d",
                  name, MinCost, MatchCount, mn, ct, cyc);
      end
      RST = 1'b1;
      @(negedge CLK);
      check({name, "_rst_valid"}, int'(Valid),      0);
      check({name, "_rst_min"},   int'(MinCost),    0);
      check({name, "_rst_cnt"},   int'(MatchCount), 0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         rom[i] = 7'($urandom_range(10, 17));

      repeat (3) @(negedge CLK);
      check("reset_w",     int'(W),          0);
      check("reset_j",     int'(J),          0);
      check("reset_min",   int'(MinCost),    0);
      check("reset_cnt",   int'(MatchCount), 0);
      check("reset_valid", int'(Valid),      0);

      // Partial search, then abort asynchronously mid-flight
      RST = 1'b0;
      repeat (3000) @(negedge CLK);
      check("mid_min",   int'(MinCost),    0);
      check("mid_cnt",   int'(MatchCount), 0);
      check("mid_valid", int'(Valid),      0);
      #2 RST = 1'b1;
      #1 check("abort_valid", int'(Valid), 0);
      repeat (2) @(negedge CLK);
      run_search("random_restart");

      for (int i = 0; i < 64; i++)
         rom[i] = 7'd127;
      run_search("all_127");

      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++)
            rom[w*8 + j] = (j == 7 - w) ? 7'd0 : 7'd100;
      run_search("anti_diag");

      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++)
            rom[w*8 + j] = (j == w) ? 7'd1 : 7'd60;
      rom[1] = 7'd1;
      rom[8] = 7'd1;
      run_search("diag_swap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
